// File: rtl/decode_pkg.sv
// Shared encodings for the LZS token parser: FSM states, token type codes and field widths.
package decode_pkg;

  localparam logic [2:0] S_TOK  = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_EXT  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] T_LIT   = 2'b00;
  localparam logic [1:0] T_MATCH = 2'b01;
  localparam logic [1:0] T_END   = 2'b10;

  localparam int unsigned LIT_BITS  = 9;
  localparam int unsigned SOFF_BITS = 9;
  localparam int unsigned LOFF_BITS = 13;
  localparam int unsigned NIB       = 4;
  localparam int unsigned EXT_BASE  = 8;

  localparam logic [3:0] NIB_CONT = 4'hF;

  // One row of the short-length code table.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] width;
    logic       ext;
  } len_ent_t;

endpackage

// File: rtl/decode_len_tab.sv
// Maps the next four stream bits onto an LZS short length code, its bit width, or the extension escape.
module decode_len_tab
  import decode_pkg::*;
(
  input  logic [3:0] nib_i,
  output len_ent_t   ent_o
);

  always_comb begin
    ent_o       = '0;
    ent_o.width = 4'(NIB);
    casez (nib_i)
      4'b00??: begin ent_o.len = 3'd2; ent_o.width = 4'd2; end
      4'b01??: begin ent_o.len = 3'd3; ent_o.width = 4'd2; end
      4'b10??: begin ent_o.len = 3'd4; ent_o.width = 4'd2; end
      4'b1100: ent_o.len = 3'd5;
      4'b1101: ent_o.len = 3'd6;
      4'b1110: ent_o.len = 3'd7;
      default: ent_o.ext = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctl.sv
// LZS token parser: consumes literal/match/end fields from a 13-bit peek window and emits tokens.
// Optional DECODE_STAT_EN adds lit_cnt/match_cnt statistics counters.
module decode_ctl
  import decode_pkg::*;
#(
  parameter int unsigned LEN_W = 16
`ifdef DECODE_STAT_EN
  , parameter int unsigned STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [12:0]       stream_data,
  input  logic              stream_valid,
  output logic [3:0]        stream_width,
  output logic              stream_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_type,
  output logic [7:0]        out_literal,
  output logic [10:0]       out_offset,
  output logic [LEN_W-1:0]  out_length,
`ifdef DECODE_STAT_EN
  output logic [STAT_W-1:0] lit_cnt,
  output logic [STAT_W-1:0] match_cnt,
`endif
  output logic              done,
  output logic              err
);

  logic [2:0]       state_q, state_d;
  logic [10:0]      off_q, off_d;
  logic [LEN_W-1:0] acc_q, acc_d;

  logic             out_valid_q;
  logic [1:0]       out_type_q;
  logic [7:0]       out_literal_q;
  logic [10:0]      out_offset_q;
  logic [LEN_W-1:0] out_length_q;

  logic             free_c;
  logic             ld;
  logic [1:0]       ld_type;
  logic [LEN_W-1:0] ld_len;
  logic [LEN_W:0]   ext_sum;
  len_ent_t         len_ent;

  decode_len_tab u_len_tab (
    .nib_i (stream_data[12:9]),
    .ent_o (len_ent)
  );

  assign free_c  = ~out_valid_q | out_ready;
  assign ext_sum = {1'b0, acc_q} + (LEN_W+1)'(stream_data[12:9]);

  // Field parsing: decides the consume width and whether a token is loaded this cycle.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    acc_d        = acc_q;
    stream_ack   = 1'b0;
    stream_width = '0;
    ld           = 1'b0;
    ld_type      = T_LIT;
    ld_len       = '0;
    case (state_q)
      S_TOK: begin
        if (stream_valid && free_c) begin
          stream_ack = 1'b1;
          if (!stream_data[12]) begin
            stream_width = 4'(LIT_BITS);
            ld           = 1'b1;
            ld_type      = T_LIT;
          end else if (stream_data[11]) begin
            stream_width = 4'(SOFF_BITS);
            off_d        = 11'(stream_data[10:4]);
            if (stream_data[10:4] == 7'd0) begin
              ld      = 1'b1;
              ld_type = T_END;
              state_d = S_DONE;
            end else begin
              state_d = S_LEN;
            end
          end else begin
            stream_width = 4'(LOFF_BITS);
            off_d        = stream_data[10:0];
            state_d      = (stream_data[10:0] == 11'd0) ? S_ERR : S_LEN;
          end
        end
      end
      S_LEN: begin
        if (stream_valid) begin
          stream_ack   = 1'b1;
          stream_width = len_ent.width;
          if (len_ent.ext) begin
            acc_d   = LEN_W'(EXT_BASE);
            state_d = S_EXT;
          end else begin
            ld      = 1'b1;
            ld_type = T_MATCH;
            ld_len  = LEN_W'(len_ent.len);
            state_d = S_TOK;
          end
        end
      end
      S_EXT: begin
        if (stream_valid) begin
          stream_ack   = 1'b1;
          stream_width = 4'(NIB);
          if (ext_sum[LEN_W]) begin
            state_d = S_ERR;
          end else if (stream_data[12:9] != NIB_CONT) begin
            ld      = 1'b1;
            ld_type = T_MATCH;
            ld_len  = ext_sum[LEN_W-1:0];
            state_d = S_TOK;
          end else begin
            acc_d = ext_sum[LEN_W-1:0];
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_TOK;
      end
      default: state_d = S_TOK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_TOK;
      off_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      acc_q   <= acc_d;
    end
  end

  // Token register: only the fields belonging to the loaded type are updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_type_q    <= '0;
      out_literal_q <= '0;
      out_offset_q  <= '0;
      out_length_q  <= '0;
    end else if (ld) begin
      out_valid_q <= 1'b1;
      out_type_q  <= ld_type;
      if (ld_type == T_LIT) out_literal_q <= stream_data[11:4];
      if (ld_type == T_MATCH) begin
        out_offset_q <= off_q;
        out_length_q <= ld_len;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_type    = out_type_q;
  assign out_literal = out_literal_q;
  assign out_offset  = out_offset_q;
  assign out_length  = out_length_q;
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);

`ifdef DECODE_STAT_EN
  logic [STAT_W-1:0] lit_cnt_q, match_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lit_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else if (ld) begin
      if (ld_type == T_LIT)   lit_cnt_q   <= lit_cnt_q + STAT_W'(1);
      if (ld_type == T_MATCH) match_cnt_q <= match_cnt_q + STAT_W'(1);
    end
  end

  assign lit_cnt   = lit_cnt_q;
  assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_decode_ctl.sv
// Bench for decode_ctl: bit-queue stream source, token encoder reference and scoreboard.
module tb_decode_ctl;

  localparam int unsigned LEN_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [12:0]       stream_data;
  logic              stream_valid;
  logic [3:0]        stream_width;
  logic              stream_ack;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_type;
  logic [7:0]        out_literal;
  logic [10:0]       out_offset;
  logic [LEN_W-1:0]  out_length;
  logic              done;
  logic              err;
`ifdef DECODE_STAT_EN
  logic [31:0]       lit_cnt;
  logic [31:0]       match_cnt;
`endif

  decode_ctl #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_width (stream_width),
    .stream_ack   (stream_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_type     (out_type),
    .out_literal  (out_literal),
    .out_offset   (out_offset),
    .out_length   (out_length),
`ifdef DECODE_STAT_EN
    .lit_cnt      (lit_cnt),
    .match_cnt    (match_cnt),
`endif
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  lit;
    logic [10:0] off;
    int unsigned len;
  } tok_t;

  typedef struct {
    logic [31:0] bits;
    int unsigned nb;
    logic        has_tok;
    logic [1:0]  typ;
    logic [7:0]  lit;
    logic [10:0] off;
    int unsigned len;
    logic        dn;
    logic        er;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          q[$];
  int unsigned consumed;
  logic        ack_s;
  logic [3:0]  w_s;
  bit          rand_mode;
  tok_t        got[$];
  tok_t        exp_q[$];
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] bits, input int unsigned nb, input logic has_tok,
                              input logic [1:0] typ, input logic [7:0] lit, input logic [10:0] off,
                              input int unsigned len, input logic dn, input logic er);
    vec_t v;
    v.bits = bits; v.nb = nb; v.has_tok = has_tok; v.typ = typ; v.lit = lit;
    v.off = off; v.len = len; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic push_bits(input logic [31:0] v, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  // Reference encoder: token -> LZS bit string, straight from the field rules.
  task automatic encode(input tok_t t);
    int unsigned r;
    if (t.typ == 2'b00) begin
      push_bits({23'd0, 1'b0, t.lit}, 9);
    end else if (t.typ == 2'b10) begin
      push_bits(32'b110000000, 9);
    end else begin
      if (t.off < 128 && $urandom_range(0, 3) != 0) push_bits({21'd0, 2'b11, t.off[6:0]}, 9);
      else push_bits({19'd0, 2'b10, t.off}, 13);
      case (t.len)
        2: push_bits(32'b00, 2);
        3: push_bits(32'b01, 2);
        4: push_bits(32'b10, 2);
        5: push_bits(32'b1100, 4);
        6: push_bits(32'b1101, 4);
        7: push_bits(32'b1110, 4);
        default: begin
          push_bits(32'hF, 4);
          r = t.len - 8;
          while (r >= 15) begin push_bits(32'hF, 4); r -= 15; end
          push_bits(r, 4);
        end
      endcase
    end
  endtask

  task automatic drive();
    logic [12:0] w;
    w = 13'($urandom);
    if (!rst && q.size() >= 13 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
      for (int i = 0; i < 13; i++) w[12-i] = q[i];
      stream_valid = 1'b1;
    end else begin
      stream_valid = 1'b0;
    end
    stream_data = w;
  endtask

  // One clock: sample handshakes before the edge, update the stream after it, return at negedge.
  task automatic tick();
    tok_t t;
    #1;
    ack_s = stream_ack;
    w_s   = stream_width;
    if (stream_ack) begin
      n_checks++;
      if (!stream_valid || stream_width == 4'd0 || stream_width > 4'd13) begin
        n_fail++;
        $display("FAIL ack_legal: got valid=%0b width=%0d, expected valid=1 width 1..13", stream_valid, stream_width);
      end
    end
    if (out_valid && out_ready) begin
      t.typ = out_type; t.lit = out_literal; t.off = out_offset; t.len = out_length;
      got.push_back(t);
    end
    @(posedge clk);
    #1;
    if (ack_s) begin
      for (int i = 0; i < int'(w_s); i++) void'(q.pop_front());
      consumed += w_s;
    end
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 2) != 0);
      start     = (q.size() > 22) && ($urandom_range(0, 15) == 0);
    end
    drive();
    @(negedge clk);
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    stream_valid = 1'b0;
    stream_data = '0;
    start = 1'b0;
    out_ready = 1'b1;
    rand_mode = 1'b0;
    q.delete();
    got.delete();
    consumed = 0;
    ack_s = 1'b0;
    w_s = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    @(negedge clk);
  endtask

  function automatic logic cond(input int unsigned what);
    case (what)
      0: return out_valid;
      1: return done;
      2: return err;
      default: return out_valid | done | err;
    endcase
  endfunction

  task automatic wait_for(input int unsigned what, input int unsigned bound, input string name);
    int unsigned c = 0;
    while (!cond(what) && c < bound) begin tick(); c++; end
    if (!cond(what)) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned n_lit;
    int unsigned n_match;
    tok_t t;

    hold_reset();
    chk("rst_ack", 32'(stream_ack), 0);
    chk("rst_width", 32'(stream_width), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_type", 32'(out_type), 0);
    chk("rst_length", 32'(out_length), 0);

    vecs.push_back(mk(32'b0_01000001, 9, 1, 2'b00, 8'h41, 0, 0, 0, 0));
    vecs.push_back(mk(32'b1_1_0000101_01, 11, 1, 2'b01, 0, 11'd5, 3, 0, 0));
    vecs.push_back(mk(32'b1_0_10000000000_1111_0011, 21, 1, 2'b01, 0, 11'h400, 11, 0, 0));
    vecs.push_back(mk(32'b1_1_0000001_1111_1111_1111_0010, 25, 1, 2'b01, 0, 11'd1, 40, 0, 0));
    vecs.push_back(mk(32'b1_1_0000000, 9, 1, 2'b10, 0, 0, 0, 1, 0));
    vecs.push_back(mk(32'b1_0_00000000000, 13, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(32'b0_11111111, 9, 1, 2'b00, 8'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(32'b0_00000000, 9, 1, 2'b00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(32'b1_0_11111111111_1110, 17, 1, 2'b01, 0, 11'd2047, 7, 0, 0));
    vecs.push_back(mk(32'b1_1_1111111_00, 11, 1, 2'b01, 0, 11'd127, 2, 0, 0));
    vecs.push_back(mk(32'b1_1_0000011_10, 11, 1, 2'b01, 0, 11'd3, 4, 0, 0));
    vecs.push_back(mk(32'b1_1_0000010_1111_0000, 17, 1, 2'b01, 0, 11'd2, 8, 0, 0));
    vecs.push_back(mk(32'b1_0_00010000000_1101, 17, 1, 2'b01, 0, 11'd128, 6, 0, 0));
    vecs.push_back(mk(32'b1_1_0000100_1100, 13, 1, 2'b01, 0, 11'd4, 5, 0, 0));

    foreach (vecs[i]) begin
      hold_reset();
      push_bits(vecs[i].bits, vecs[i].nb);
      push_bits(0, 16);
      release_reset();
      wait_for(3, 40, $sformatf("v%0d", i));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].has_tok));
      chk($sformatf("v%0d_consumed", i), consumed, vecs[i].nb);
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
      if (vecs[i].has_tok) begin
        chk($sformatf("v%0d_type", i), 32'(out_type), 32'(vecs[i].typ));
        if (vecs[i].typ == 2'b00) chk($sformatf("v%0d_lit", i), 32'(out_literal), 32'(vecs[i].lit));
        if (vecs[i].typ == 2'b01) begin
          chk($sformatf("v%0d_off", i), 32'(out_offset), 32'(vecs[i].off));
          chk($sformatf("v%0d_len", i), 32'(out_length), vecs[i].len);
        end
      end
    end

    // End marker parks the parser until start.
    hold_reset();
    push_bits(32'b1_1_0000000, 9);
    push_bits(32'b0_01000001, 9);
    push_bits(0, 16);
    release_reset();
    wait_for(1, 20, "end_wait");
    chk("end_type", 32'(out_type), 2);
    repeat (4) tick();
    chk("end_no_ack", consumed, 9);
    chk("end_drained", 32'(out_valid), 0);
    chk("end_done_held", 32'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("end_start_done", 32'(done), 0);
    wait_for(0, 20, "end_resume");
    chk("end_resume_lit", 32'(out_literal), 32'h41);
    chk("end_resume_type", 32'(out_type), 0);

    // Zero long offset goes to error and stays until start.
    hold_reset();
    push_bits(32'b1_0_00000000000, 13);
    push_bits(32'b0_10101010, 9);
    push_bits(0, 16);
    release_reset();
    wait_for(2, 20, "err_wait");
    repeat (3) tick();
    chk("err_no_ack", consumed, 13);
    chk("err_held", 32'(err), 1);
    chk("err_no_tok", 32'(out_valid), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", 32'(err), 0);
    wait_for(0, 20, "err_resume");
    chk("err_resume_lit", 32'(out_literal), 32'hAA);

    // Sink stall with literals queued.
    hold_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push_bits({23'd0, 1'b0, 8'(8'h10 + k)}, 9);
    push_bits(0, 16);
    release_reset();
    wait_for(0, 20, "stall_wait");
    chk("stall_first", 32'(out_literal), 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_hold%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("stall_hold%0d_lit", k), 32'(out_literal), 32'h10);
      chk($sformatf("stall_hold%0d_cons", k), consumed, 9);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("stall_run%0d_lit", k), 32'(out_literal), 32'(8'h10 + k));
      chk($sformatf("stall_run%0d_cons", k), consumed, 32'(9 * (k + 1)));
    end

    // Largest representable length.
    hold_reset();
    push_bits(32'b1_1_0000001, 9);
    push_bits(32'hF, 4);
    for (int k = 0; k < 4368; k++) push_bits(32'hF, 4);
    push_bits(32'h7, 4);
    push_bits(0, 16);
    release_reset();
    wait_for(0, 6000, "maxlen_wait");
    chk("maxlen_len", 32'(out_length), 65535);
    chk("maxlen_off", 32'(out_offset), 1);
    chk("maxlen_err", 32'(err), 0);

    // One more continuation nibble overflows the length.
    hold_reset();
    push_bits(32'b1_1_0000001, 9);
    push_bits(32'hF, 4);
    for (int k = 0; k < 4369; k++) push_bits(32'hF, 4);
    push_bits(0, 16);
    release_reset();
    wait_for(2, 6000, "ovf_wait");
    chk("ovf_err", 32'(err), 1);
    chk("ovf_no_tok", 32'(out_valid), 0);
    chk("ovf_consumed", consumed, 9 + 4 + 4369 * 4);

    // Reset in the middle of an extended length discards it.
    hold_reset();
    push_bits(32'b1_1_0000001_1111, 13);
    push_bits(0, 16);
    release_reset();
    repeat (2) tick();
    chk("midrst_consumed", consumed, 13);
    hold_reset();
    push_bits(32'b0_01011010, 9);
    push_bits(0, 16);
    release_reset();
    wait_for(0, 20, "midrst_wait");
    chk("midrst_type", 32'(out_type), 0);
    chk("midrst_lit", 32'(out_literal), 32'h5A);

    // Random token stream with stream/sink stalls and stray start pulses.
    hold_reset();
    exp_q.delete();
    n_lit = 0;
    n_match = 0;
    for (int k = 0; k < 400; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        t.typ = 2'b00; t.lit = 8'($urandom); t.off = 0; t.len = 0;
        n_lit++;
      end else begin
        t.typ = 2'b01; t.lit = 0;
        t.off = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(1, 127)) : 11'($urandom_range(1, 2047));
        r = $urandom_range(0, 9);
        if (r < 6) t.len = $urandom_range(2, 7);
        else if (r < 9) t.len = $urandom_range(8, 60);
        else t.len = $urandom_range(61, 400);
        n_match++;
      end
      exp_q.push_back(t);
      encode(t);
    end
    t.typ = 2'b10; t.lit = 0; t.off = 0; t.len = 0;
    exp_q.push_back(t);
    encode(t);
    push_bits(0, 13);
    rand_mode = 1'b1;
    release_reset();
    wait_for(1, 20000, "rand_done");
    rand_mode = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rand_err", 32'(err), 0);
    chk("rand_count", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      chk($sformatf("rand%0d_type", k), 32'(got[k].typ), 32'(exp_q[k].typ));
      if (exp_q[k].typ == 2'b00) chk($sformatf("rand%0d_lit", k), 32'(got[k].lit), 32'(exp_q[k].lit));
      if (exp_q[k].typ == 2'b01) begin
        chk($sformatf("rand%0d_off", k), 32'(got[k].off), 32'(exp_q[k].off));
        chk($sformatf("rand%0d_len", k), got[k].len, exp_q[k].len);
      end
    end
`ifdef DECODE_STAT_EN
    chk("stat_lit", lit_cnt, n_lit);
    chk("stat_match", match_cnt, n_match);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
